// File: rtl/ccd_timing_gen_if.sv
// Control/timing bundle between the CCD timing generator and its user.
// The user (master) owns run enable and gap length; the generator (slave)
// drives the sensor clocks, sample strobe and line framing.
interface ccd_timing_gen_if;
    logic        en;
    logic [15:0] gap_cycles;
    logic        sh;
    logic        phi1;
    logic        phi2;
    logic        rs;
    logic        cdsclk1;
    logic [11:0] pix_idx;
    logic        line_active;
    logic        line_done;
    logic        busy;

    modport master (
        output en, gap_cycles,
        input  sh, phi1, phi2, rs, cdsclk1, pix_idx, line_active, line_done, busy
    );

    modport slave (
        input  en, gap_cycles,
        output sh, phi1, phi2, rs, cdsclk1, pix_idx, line_active, line_done, busy
    );
endinterface

// File: rtl/ccd_timing_gen.sv
// Linear-CCD line readout timing: transfer gate, two-phase shift clocks,
// reset gate and ADC sample strobe, plus pixel index and line framing.
// All outputs are registered from the current state/counters, so they lag
// the state by one clock.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | parked, phi1 high; en starts a line and latches gap_cycles
// PRE   | GUARD cycles of quiet before the transfer gate
// SH    | SH_W cycles with sh high (charge transfer)
// POST  | GUARD cycles of quiet after the transfer gate
// READ  | N_PIX * PIX_DIV cycles of pixel shifting and sampling
// GAP   | gap_reg idle cycles, then en decides PRE or IDLE
module ccd_timing_gen #(
    parameter int N_PIX   = 3694,
    parameter int PIX_DIV = 8,
    parameter int SAMP_PH = 5,
    parameter int SH_W    = 100,
    parameter int GUARD   = 50
) (
    input  logic              clk,
    input  logic              rst,
    ccd_timing_gen_if.slave   bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_SH   = 3'd2;
    localparam logic [2:0] S_POST = 3'd3;
    localparam logic [2:0] S_READ = 3'd4;
    localparam logic [2:0] S_GAP  = 3'd5;

    // Down-counter reload values are length-1 so terminal count is zero.
    localparam logic [15:0] GUARD_LD = 16'(GUARD - 1);
    localparam logic [15:0] SH_LD    = 16'(SH_W - 1);
    localparam logic [7:0]  PH_LAST  = 8'(PIX_DIV - 1);
    localparam logic [7:0]  PH_HALF  = 8'(PIX_DIV / 2);
    localparam logic [7:0]  SAMP_A   = 8'(SAMP_PH);
    localparam logic [7:0]  SAMP_B   = 8'(SAMP_PH + 1);
    localparam logic [11:0] PC_LAST  = 12'(N_PIX - 1);

    logic [2:0]  state_q, state_d;
    logic [15:0] tmr_q, tmr_d;
    logic [15:0] gap_q, gap_d;
    logic [7:0]  ph_q, ph_d;
    logic [11:0] pc_q, pc_d;

    logic        sh_q, sh_d;
    logic        phi1_q, phi1_d;
    logic        phi2_q, phi2_d;
    logic        rs_q, rs_d;
    logic        cds_q, cds_d;
    logic [11:0] pix_q, pix_d;
    logic        act_q, act_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;

    logic        tmr_tc;
    logic        en_check;
    logic        last_cycle;

    assign tmr_tc     = (tmr_q == 16'd0);
    assign last_cycle = (ph_q == PH_LAST) && (pc_q == PC_LAST);

    // Next-state, timer, pixel/phase counters and gap latch.
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        gap_d    = gap_q;
        ph_d     = ph_q;
        pc_d     = pc_q;
        en_check = 1'b0;
        case (state_q)
            S_IDLE: en_check = 1'b1;
            S_PRE: begin
                if (tmr_tc) begin
                    state_d = S_SH;
                    tmr_d   = SH_LD;
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            S_SH: begin
                if (tmr_tc) begin
                    state_d = S_POST;
                    tmr_d   = GUARD_LD;
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            S_POST: begin
                if (tmr_tc) begin
                    state_d = S_READ;
                    ph_d    = 8'd0;
                    pc_d    = 12'd0;
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            S_READ: begin
                if (ph_q == PH_LAST) begin
                    ph_d = 8'd0;
                    if (pc_q == PC_LAST) begin
                        if (gap_q != 16'd0) begin
                            state_d = S_GAP;
                            tmr_d   = gap_q - 16'd1;
                        end else begin
                            en_check = 1'b1;
                        end
                    end else begin
                        pc_d = pc_q + 12'd1;
                    end
                end else begin
                    ph_d = ph_q + 8'd1;
                end
            end
            S_GAP: begin
                if (tmr_tc) begin
                    en_check = 1'b1;
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line boundary: en is only looked at here, so a line always completes.
        if (en_check) begin
            if (bus.en) begin
                state_d = S_PRE;
                tmr_d   = GUARD_LD;
                gap_d   = bus.gap_cycles;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    // Output levels decoded from the current state; registered below.
    always_comb begin
        sh_d   = 1'b0;
        phi1_d = 1'b1;
        phi2_d = 1'b0;
        rs_d   = 1'b0;
        cds_d  = 1'b0;
        pix_d  = 12'd0;
        act_d  = 1'b0;
        done_d = 1'b0;
        busy_d = (state_q != S_IDLE);
        case (state_q)
            S_SH: sh_d = 1'b1;
            S_READ: begin
                phi1_d = (ph_q < PH_HALF);
                phi2_d = !(ph_q < PH_HALF);
                rs_d   = (ph_q == 8'd0);
                cds_d  = (ph_q == SAMP_A) || (ph_q == SAMP_B);
                pix_d  = pc_q;
                act_d  = 1'b1;
                done_d = last_cycle;
            end
            default: ;
        endcase
    end

    // State and counter registers; reset aborts any line in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tmr_q   <= 16'd0;
            gap_q   <= 16'd0;
            ph_q    <= 8'd0;
            pc_q    <= 12'd0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            gap_q   <= gap_d;
            ph_q    <= ph_d;
            pc_q    <= pc_d;
        end
    end

    // Output registers; all clear to 0 in reset, phi1 included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q   <= 1'b0;
            phi1_q <= 1'b0;
            phi2_q <= 1'b0;
            rs_q   <= 1'b0;
            cds_q  <= 1'b0;
            pix_q  <= 12'd0;
            act_q  <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            phi1_q <= phi1_d;
            phi2_q <= phi2_d;
            rs_q   <= rs_d;
            cds_q  <= cds_d;
            pix_q  <= pix_d;
            act_q  <= act_d;
            done_q <= done_d;
            busy_q <= busy_d;
        end
    end

    assign bus.sh          = sh_q;
    assign bus.phi1        = phi1_q;
    assign bus.phi2        = phi2_q;
    assign bus.rs          = rs_q;
    assign bus.cdsclk1     = cds_q;
    assign bus.pix_idx     = pix_q;
    assign bus.line_active = act_q;
    assign bus.line_done   = done_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_ccd_timing_gen.sv
// Bench for ccd_timing_gen with N_PIX=4, PIX_DIV=8, SAMP_PH=5, SH_W=4, GUARD=2.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ccd_timing_gen;

    typedef struct packed {
        logic        sh;
        logic        phi1;
        logic        phi2;
        logic        rs;
        logic        cds;
        logic [11:0] pix;
        logic        la;
        logic        ld;
        logic        busy;
    } out_t;

    typedef struct {
        logic        en;
        logic [15:0] gap;
        out_t        exp;
    } vec_t;

    localparam int NV = 96;

    logic clk;
    logic rst;
    int   chk_cnt;
    int   fail_cnt;
    vec_t vecs[NV];

    ccd_timing_gen_if bus();

    ccd_timing_gen #(
        .N_PIX(4), .PIX_DIV(8), .SAMP_PH(5), .SH_W(4), .GUARD(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic out_t sample();
        out_t o;
        o = {bus.sh, bus.phi1, bus.phi2, bus.rs, bus.cdsclk1, bus.pix_idx,
             bus.line_active, bus.line_done, bus.busy};
        return o;
    endfunction

    // Expected outputs for state offset s from the first PRE cycle.
    // Line 1 has gap 3 (period 43); every later line has gap 10 (period 50).
    // Line layout: PRE 0-1, SH 2-5, POST 6-7, READ 8-39, GAP from 40.
    function automatic out_t model(int s);
        out_t o;
        int   r;
        int   ph;
        o = '0;
        o.phi1 = 1'b1;
        if (s < 0) return o;
        if (s >= 43) begin
            s = s - 43;
            while (s >= 50) s = s - 50;
        end
        o.busy = 1'b1;
        if (s >= 2 && s < 6) begin
            o.sh = 1'b1;
        end else if (s >= 8 && s < 40) begin
            r      = s - 8;
            ph     = r % 8;
            o.phi1 = (ph < 4);
            o.phi2 = !(ph < 4);
            o.rs   = (ph == 0);
            o.cds  = (ph == 5) || (ph == 6);
            o.pix  = 12'(r / 8);
            o.la   = 1'b1;
            o.ld   = (r == 31);
        end
        return o;
    endfunction

    task automatic check_out(input string name, input out_t act, input out_t exp);
        chk_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        chk_cnt++;
        if (act != exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.en = 1'b0;
        bus.gap_cycles = 16'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    out_t idle_o;
    out_t cur;

    initial begin
        int   ld_t[$];
        int   busy_drop;
        int   seen_busy;
        int   prev_ld;
        int   cds_rises;
        int   ld_cnt;
        int   gap_busy;
        int   dropped;
        int   prev_cds;
        int   found;
        int   rise_at;
        int   idle_busy;
        int   state;

        clk = 1'b0;
        rst = 1'b0;
        chk_cnt = 0;
        fail_cnt = 0;
        bus.en = 1'b0;
        bus.gap_cycles = 16'd0;
        idle_o = '0;
        idle_o.phi1 = 1'b1;

        for (int i = 0; i < NV; i++) begin
            vecs[i].en  = 1'b1;
            vecs[i].gap = (i < 20) ? 16'd3 : 16'd10;
            vecs[i].exp = model(i - 1);
        end

        // Reset: every output 0, phi1 included.
        #2 rst = 1'b1;
        #1 check_out("reset_outputs", sample(), '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_out("idle_levels", sample(), idle_o);

        // Two full lines, gap_cycles changed 3 -> 10 during line 1's READ.
        for (int i = 0; i < NV; i++) begin
            bus.en = vecs[i].en;
            bus.gap_cycles = vecs[i].gap;
            @(negedge clk);
            check_out($sformatf("vec%0d", i), sample(), vecs[i].exp);
        end

        // gap_cycles = 0 with en held: back-to-back lines of 40 cycles.
        apply_reset();
        bus.en = 1'b1;
        bus.gap_cycles = 16'd0;
        busy_drop = 0;
        seen_busy = 0;
        prev_ld = 0;
        for (int n = 1; n <= 160; n++) begin
            @(negedge clk);
            cur = sample();
            if (cur.busy) seen_busy = 1;
            else if (seen_busy != 0) busy_drop++;
            if (cur.ld) ld_t.push_back(n);
            prev_ld = int'(cur.ld);
        end
        check_int("b2b_line_done_count", ld_t.size(), 3);
        check_int("b2b_busy_drops", busy_drop, 0);
        if (ld_t.size() >= 3) begin
            check_int("b2b_first_done", ld_t[0], 41);
            check_int("b2b_period_1", ld_t[1] - ld_t[0], 40);
            check_int("b2b_period_2", ld_t[2] - ld_t[1], 40);
        end

        // en dropped during pixel 1: line completes, 3-cycle gap, then IDLE.
        apply_reset();
        bus.en = 1'b1;
        bus.gap_cycles = 16'd3;
        cds_rises = 0;
        ld_cnt = 0;
        gap_busy = 0;
        dropped = 0;
        prev_cds = 0;
        state = 0;
        for (int n = 0; n < 200 && state < 2; n++) begin
            @(negedge clk);
            cur = sample();
            if (cur.cds && prev_cds == 0) cds_rises++;
            prev_cds = int'(cur.cds);
            if (state == 0) begin
                if (cur.ld) begin
                    ld_cnt++;
                    state = 1;
                end
                if (cur.cds && cur.pix == 12'd1 && bus.en) begin
                    bus.en = 1'b0;
                    dropped = 1;
                end
            end else begin
                if (cur.busy) gap_busy++;
                else state = 2;
            end
        end
        check_int("drop_en_reached", dropped, 1);
        check_int("drop_cds_pulses", cds_rises, 4);
        check_int("drop_line_done", ld_cnt, 1);
        check_int("drop_gap_len", gap_busy, 3);
        check_out("drop_idle_levels", cur, idle_o);
        idle_busy = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.busy) idle_busy++;
        end
        check_int("drop_stays_idle", idle_busy, 0);

        // Reset during SH: async clear, then IDLE until en.
        apply_reset();
        bus.en = 1'b1;
        bus.gap_cycles = 16'd3;
        found = 0;
        for (int n = 0; n < 20 && found == 0; n++) begin
            @(negedge clk);
            if (bus.sh) found = 1;
        end
        check_int("rst_sh_reached", found, 1);
        #1 rst = 1'b1;
        #1 check_out("rst_async_clear", sample(), '0);
        @(negedge clk);
        rst = 1'b0;
        bus.en = 1'b0;
        @(negedge clk);
        check_out("rst_release_idle", sample(), idle_o);
        idle_busy = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.busy) idle_busy++;
        end
        check_int("rst_no_restart", idle_busy, 0);
        bus.en = 1'b1;
        rise_at = 0;
        for (int n = 1; n <= 4 && rise_at == 0; n++) begin
            @(negedge clk);
            if (bus.busy) rise_at = n;
        end
        check_int("rst_en_restart", rise_at, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
        $finish;
    end

endmodule
